// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the uart_core echo controller: register map,
// FSM state encoding and the per-state bus command decoder.
package uart_ctrl_pkg;

  // uart_core register addresses
  localparam logic [11:0] ADDR_DIV    = 12'h000;
  localparam logic [11:0] ADDR_TXDATA = 12'h004;
  localparam logic [11:0] ADDR_RXDATA = 12'h008;
  localparam logic [11:0] ADDR_RXEN   = 12'h00C;
  localparam logic [11:0] ADDR_TXLVL  = 12'h018;
  localparam logic [11:0] ADDR_TXEN   = 12'h01C;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CFG_BAUD  = 4'd1,
    ST_CFG_TXLVL = 4'd2,
    ST_RX_EN     = 4'd3,
    ST_WAIT_RX   = 4'd4,
    ST_RD_REQ    = 4'd5,
    ST_RD_CAP    = 4'd6,
    ST_RX_DIS    = 4'd7,
    ST_WR_DATA   = 4'd8,
    ST_TX_GO     = 4'd9,
    ST_TX_CLR    = 4'd10,
    ST_WAIT_TX   = 4'd11
  } state_e;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [11:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  // Bus command driven while the FSM sits in state st. Non-bus states
  // return an all-zero command so address and data stay quiet.
  function automatic bus_cmd_t bus_cmd(input state_e st,
                                       input logic [31:0] div,
                                       input logic [7:0] tx_byte);
    bus_cmd_t c;
    c = '{we: 1'b0, re: 1'b0, addr: 12'h000, wdata: 32'h0000_0000};
    case (st)
      ST_CFG_BAUD:  c = '{we: 1'b1, re: 1'b0, addr: ADDR_DIV,    wdata: div};
      ST_CFG_TXLVL: c = '{we: 1'b1, re: 1'b0, addr: ADDR_TXLVL,  wdata: 32'h0000_0000};
      ST_RX_EN:     c = '{we: 1'b1, re: 1'b0, addr: ADDR_RXEN,   wdata: 32'h0000_0001};
      ST_RD_REQ:    c = '{we: 1'b0, re: 1'b1, addr: ADDR_RXDATA, wdata: 32'h0000_0000};
      ST_RX_DIS:    c = '{we: 1'b1, re: 1'b0, addr: ADDR_RXEN,   wdata: 32'h0000_0000};
      ST_WR_DATA:   c = '{we: 1'b1, re: 1'b0, addr: ADDR_TXDATA, wdata: {24'h00_0000, tx_byte}};
      ST_TX_GO:     c = '{we: 1'b1, re: 1'b0, addr: ADDR_TXEN,   wdata: 32'h0000_0001};
      ST_TX_CLR:    c = '{we: 1'b1, re: 1'b0, addr: ADDR_TXEN,   wdata: 32'h0000_0000};
      default:      c = '{we: 1'b0, re: 1'b0, addr: 12'h000,     wdata: 32'h0000_0000};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_echo_ctrl.sv
// Register-bus master that runs a uart_core echo loop: configure baud and
// TX level, enable RX, read each received byte and send it back out.
module uart_echo_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [31:0] CLK_DIV    = 32'd43,
  parameter logic [15:0] TX_TIMEOUT = 16'd4096,
  parameter logic [7:0]  MATCH_CHAR = 8'd97
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        start_i,
  input  logic        intr_rx,
  input  logic        intr_tx,
  input  logic [31:0] reg_rdata,
  output logic        reg_we,
  output logic        reg_re,
  output logic [11:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic        busy_o,
  output logic [7:0]  last_byte_o,
  output logic [15:0] byte_cnt_o,
  output logic        match_o,
  output logic        err_o
);

  state_e      r_state;
  bus_cmd_t    r_bus;
  logic        r_busy;
  logic [7:0]  r_last_byte;
  logic [15:0] r_byte_cnt;
  logic        r_match;
  logic        r_err;
  logic [15:0] r_timer;

  state_e      w_next_state;
  logic        w_tx_timeout;
  logic        w_unused_rdata;

  // Only the low byte of the RX data register carries the received character.
  assign w_unused_rdata = ^reg_rdata[31:8];

  // Next-state decode; the interrupts only matter in the two wait states.
  always_comb begin
    w_next_state = r_state;
    w_tx_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_next_state = ST_CFG_BAUD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CFG_BAUD:  w_next_state = ST_CFG_TXLVL;
      ST_CFG_TXLVL: w_next_state = ST_RX_EN;
      ST_RX_EN:     w_next_state = ST_WAIT_RX;
      ST_WAIT_RX: begin
        // A pending byte wins over a stop request so it is never stranded.
        if (intr_rx) begin
          w_next_state = ST_RD_REQ;
        end else if (!start_i) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT_RX;
        end
      end
      ST_RD_REQ:  w_next_state = ST_RD_CAP;
      ST_RD_CAP:  w_next_state = ST_RX_DIS;
      ST_RX_DIS:  w_next_state = ST_WR_DATA;
      ST_WR_DATA: w_next_state = ST_TX_GO;
      ST_TX_GO:   w_next_state = ST_TX_CLR;
      ST_TX_CLR:  w_next_state = ST_WAIT_TX;
      ST_WAIT_TX: begin
        // TX-done in the expiry cycle counts as success, not a timeout.
        if (intr_tx) begin
          w_next_state = start_i ? ST_RX_EN : ST_IDLE;
        end else if (r_timer == (TX_TIMEOUT - 16'd1)) begin
          w_tx_timeout = 1'b1;
          w_next_state = start_i ? ST_RX_EN : ST_IDLE;
        end else begin
          w_next_state = ST_WAIT_TX;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, registered bus command for the state being entered, capture and status.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bus       <= '{we: 1'b0, re: 1'b0, addr: 12'h000, wdata: 32'h0000_0000};
      r_busy      <= 1'b0;
      r_last_byte <= 8'h00;
      r_byte_cnt  <= 16'h0000;
      r_match     <= 1'b0;
      r_err       <= 1'b0;
      r_timer     <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      // Loading the command of the next state makes every strobe coincide
      // with its state and come straight from a flop.
      r_bus   <= bus_cmd(w_next_state, CLK_DIV, r_last_byte);
      r_busy  <= (w_next_state != ST_IDLE);

      if (r_state == ST_RD_CAP) begin
        r_last_byte <= reg_rdata[7:0];
        r_byte_cnt  <= r_byte_cnt + 16'd1;
      end

      // Compare lands one cycle after the capture, while in RX_DIS.
      if (r_state == ST_RX_DIS) begin
        r_match <= (r_last_byte == MATCH_CHAR);
      end

      // Timer runs only while waiting for TX-done; zero on entry.
      if (r_state == ST_WAIT_TX) begin
        r_timer <= r_timer + 16'd1;
      end else begin
        r_timer <= 16'h0000;
      end

      if (w_tx_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign reg_we      = r_bus.we;
  assign reg_re      = r_bus.re;
  assign reg_addr    = r_bus.addr;
  assign reg_wdata   = r_bus.wdata;
  assign busy_o      = r_busy;
  assign last_byte_o = r_last_byte;
  assign byte_cnt_o  = r_byte_cnt;
  assign match_o     = r_match;
  assign err_o       = r_err;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Bench for uart_echo_ctrl: a small uart_core stand-in answers the register
// bus, and a cycle-scheduled reference model predicts every output.
module tb_uart_echo_ctrl;

  localparam int          TO    = 4096;
  localparam logic [31:0] DIV   = 32'd43;
  localparam logic [7:0]  MATCH = 8'd97;

  logic        clk;
  logic        rst;
  logic        start;
  logic        intr_rx;
  logic        intr_tx;
  logic [31:0] reg_rdata;
  logic        reg_we;
  logic        reg_re;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        busy_o;
  logic [7:0]  last_byte_o;
  logic [15:0] byte_cnt_o;
  logic        match_o;
  logic        err_o;

  uart_echo_ctrl #(.CLK_DIV(DIV), .TX_TIMEOUT(16'd4096), .MATCH_CHAR(MATCH)) dut (
    .clk_i(clk), .rst(rst), .start_i(start), .intr_rx(intr_rx), .intr_tx(intr_tx),
    .reg_rdata(reg_rdata), .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .busy_o(busy_o), .last_byte_o(last_byte_o),
    .byte_cnt_o(byte_cnt_o), .match_o(match_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- uart_core stand-in ----------------
  logic [7:0] rx_q[$];      // bytes waiting in the RX FIFO
  logic [7:0] tx_log[$];    // bytes written to TXDATA
  logic [7:0] sent_log[$];  // every byte the bench injected
  bit         force_tx_low = 1'b0;
  bit         prev_re      = 1'b0;
  int         tx_cnt       = 0;

  initial begin
    logic [31:0] rnd;
    intr_rx = 1'b0; intr_tx = 1'b0; reg_rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      rnd = $urandom();
      if (prev_re && rx_q.size() != 0) reg_rdata = {rnd[31:8], rx_q.pop_front()};
      else reg_rdata = rnd;
      prev_re = reg_re && (reg_addr == 12'h008);
      if (reg_we && reg_addr == 12'h004) tx_log.push_back(reg_wdata[7:0]);
      intr_tx = 1'b0;
      if (reg_we && reg_addr == 12'h01C && reg_wdata == 32'd1 && !force_tx_low)
        tx_cnt = int'($urandom_range(3, 12));
      else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) intr_tx = 1'b1;
      end else if (!force_tx_low && $urandom_range(0, 15) == 0)
        intr_tx = 1'b1;  // stray pulse while no transmit is in flight
      intr_rx = (rx_q.size() != 0);
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic we; logic re; logic [11:0] addr; logic [31:0] wdata;
    logic busy; logic [7:0] last; logic [15:0] cnt; logic match; logic err;
  } obs_t;

  typedef enum int {M_IDLE, M_SEQ, M_WRX, M_WTX} mode_e;

  obs_t        ring[16];
  mode_e       mode = M_IDLE, seq_next = M_IDLE;
  int          seq_end = 0, sched_until = 0, wtx_first = 0;
  bit          m_valid = 1'b0;
  logic [7:0]  p_last = 8'h00;
  logic [15:0] p_cnt = 16'h0;
  logic        p_match = 1'b0, p_err = 1'b0;

  function automatic obs_t mk(input logic we, input logic re, input logic [11:0] a,
                              input logic [31:0] d, input logic busy);
    return {we, re, a, d, busy, p_last, p_cnt, p_match, p_err};
  endfunction

  task automatic put(input int cc, input obs_t o);
    ring[cc % 16] = o;
    sched_until = cc;
  endtask

  task automatic go_seq(input int e, input mode_e nxt);
    mode = M_SEQ; seq_end = e; seq_next = nxt;
  endtask

  // Decide, from the inputs the DUT will sample at the end of cycle c,
  // what every following cycle must look like.
  task automatic model_step(input int c);
    logic [7:0] b;
    bit ex;
    if (rst) begin
      mode = M_IDLE; p_last = 8'h00; p_cnt = 16'h0; p_match = 1'b0; p_err = 1'b0;
      sched_until = c; m_valid = 1'b1;
    end else if (m_valid) begin
      case (mode)
        M_IDLE: if (start) begin
          put(c + 1, mk(1'b1, 1'b0, 12'h000, DIV, 1'b1));
          put(c + 2, mk(1'b1, 1'b0, 12'h018, 32'd0, 1'b1));
          put(c + 3, mk(1'b1, 1'b0, 12'h00C, 32'd1, 1'b1));
          go_seq(c + 3, M_WRX);
        end
        M_SEQ: if (c == seq_end) mode = seq_next;
        M_WRX: if (intr_rx) begin
          b = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
          put(c + 1, mk(1'b0, 1'b1, 12'h008, 32'd0, 1'b1));
          put(c + 2, mk(1'b0, 1'b0, 12'h000, 32'd0, 1'b1));
          p_last = b; p_cnt = p_cnt + 16'd1;
          put(c + 3, mk(1'b1, 1'b0, 12'h00C, 32'd0, 1'b1));
          p_match = (b == MATCH);
          put(c + 4, mk(1'b1, 1'b0, 12'h004, {24'h0, b}, 1'b1));
          put(c + 5, mk(1'b1, 1'b0, 12'h01C, 32'd1, 1'b1));
          put(c + 6, mk(1'b1, 1'b0, 12'h01C, 32'd0, 1'b1));
          wtx_first = c + 7;
          go_seq(c + 6, M_WTX);
        end else if (!start) mode = M_IDLE;
        M_WTX: begin
          ex = 1'b0;
          if (intr_tx) ex = 1'b1;
          else if (c - wtx_first == TO - 1) begin ex = 1'b1; p_err = 1'b1; end
          if (ex) begin
            if (start) begin
              put(c + 1, mk(1'b1, 1'b0, 12'h00C, 32'd1, 1'b1));
              go_seq(c + 1, M_WRX);
            end else mode = M_IDLE;
          end
        end
        default: mode = M_IDLE;
      endcase
    end
    if (sched_until < c + 1) ring[(c + 1) % 16] = mk(1'b0, 1'b0, 12'h000, 32'd0, mode != M_IDLE);
  endtask

  // Per-cycle compare of every output against the model.
  initial begin
    obs_t o;
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        o = {reg_we, reg_re, reg_addr, reg_wdata, busy_o, last_byte_o, byte_cnt_o, match_o, err_o};
        check($sformatf("cycle_%0d", c), 80'(o), 80'(ring[c % 16]));
        check("we_re_exclusive", 80'(reg_we & reg_re), 80'(1'b0));
      end
      model_step(c);
      c++;
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
    sent_log.push_back(b);
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      if (byte_cnt_o == target) break;
    end
    check("wait_byte_cnt", 80'(byte_cnt_o), 80'(target));
  endtask

  initial begin
    longint t_clr, t_err;
    int     bad, writes;
    bit     seen;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", 80'({reg_we, reg_re, reg_addr, reg_wdata, busy_o, last_byte_o,
                               byte_cnt_o, match_o, err_o}), 80'(0));

    // Configuration burst right after start.
    tick(); start = 1'b1;
    tick(); check("cfg_baud",  80'({reg_we, reg_re, reg_addr, reg_wdata}), 80'({1'b1, 1'b0, 12'h000, 32'd43}));
    tick(); check("cfg_txlvl", 80'({reg_we, reg_re, reg_addr, reg_wdata}), 80'({1'b1, 1'b0, 12'h018, 32'd0}));
    tick(); check("rx_en",     80'({reg_we, reg_re, reg_addr, reg_wdata}), 80'({1'b1, 1'b0, 12'h00C, 32'd1}));
    check("busy_after_start", 80'(busy_o), 80'(1'b1));

    // Single matching byte.
    send(8'h61);
    wait_cnt(16'd1, 200);
    repeat (20) tick();
    check("first_last_byte", 80'(last_byte_o), 80'(8'h61));
    check("first_match", 80'(match_o), 80'(1'b1));
    check("first_tx_byte", 80'(tx_log.size() > 0 ? tx_log[0] : 8'h00), 80'(8'h61));

    // Back-to-back burst.
    send(8'h55); send(8'h5A); send(8'h41);
    wait_cnt(16'd4, 300);
    repeat (20) tick();
    check("burst_tx_count", 80'(tx_log.size()), 80'(4));
    check("burst_order", 80'({tx_log[1], tx_log[2], tx_log[3]}), 80'(24'h555A41));
    check("burst_last_byte", 80'(last_byte_o), 80'(8'h41));
    check("burst_match", 80'(match_o), 80'(1'b0));

    // Random traffic with occasional stop requests.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 30)) tick();
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b0;
        repeat ($urandom_range(1, 20)) tick();
        start = 1'b1;
      end
      send(($urandom_range(0, 3) == 0) ? MATCH : 8'($urandom()));
    end
    start = 1'b1;
    wait_cnt(16'd64, 4000);
    repeat (30) tick();
    bad = 0;
    for (int i = 0; i < sent_log.size(); i++)
      if (i >= tx_log.size() || tx_log[i] !== sent_log[i]) bad++;
    check("random_echo_order", 80'(bad), 80'(0));

    // TX-done never arrives.
    force_tx_low = 1'b1;
    send(8'h33);
    seen = 1'b0; t_clr = 0; t_err = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      tick();
      if (reg_we && reg_addr == 12'h01C && reg_wdata == 32'd0) begin seen = 1'b1; t_clr = $time; end
    end
    check("timeout_tx_clr_seen", 80'(seen), 80'(1'b1));
    seen = 1'b0;
    for (int k = 0; k < TO + 100 && !seen; k++) begin
      tick();
      if (err_o) begin seen = 1'b1; t_err = $time; end
    end
    check("timeout_err_set", 80'(err_o), 80'(1'b1));
    // 4096 wait cycles after TX_CLR, flag visible the cycle after.
    check("timeout_latency", 80'((t_err - t_clr) / 10), 80'(TO + 1));
    check("timeout_back_to_rx_en", 80'({reg_we, reg_addr, reg_wdata}), 80'({1'b1, 12'h00C, 32'd1}));
    force_tx_low = 1'b0;
    repeat (5) tick();

    // Stop requested during WR_DATA: byte finishes, then the controller parks.
    send(8'h7E);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick();
      if (reg_we && reg_addr == 12'h004) begin seen = 1'b1; start = 1'b0; end
    end
    check("stop_wr_data_seen", 80'(seen), 80'(1'b1));
    for (int k = 0; k < 100 && busy_o; k++) tick();
    check("stop_idle", 80'(busy_o), 80'(1'b0));
    check("stop_byte_echoed", 80'(tx_log.size() > 0 ? tx_log[tx_log.size() - 1] : 8'h00), 80'(8'h7E));
    send(8'h10);
    writes = 0;
    repeat (30) begin tick(); if (reg_we || reg_re) writes++; end
    check("stop_no_bus_activity", 80'(writes), 80'(0));
    check("stop_count", 80'(byte_cnt_o), 80'(16'd66));

    // Reset while waiting for TX-done.
    force_tx_low = 1'b1;
    start = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      tick();
      if (reg_we && reg_addr == 12'h01C && reg_wdata == 32'd0) seen = 1'b1;
    end
    check("rst_tx_clr_seen", 80'(seen), 80'(1'b1));
    tick();
    rst = 1'b1;
    tick();
    check("rst_in_wait_tx", 80'({reg_we, reg_re, reg_addr, reg_wdata, busy_o, last_byte_o,
                                byte_cnt_o, match_o, err_o}), 80'(0));
    rst = 1'b0; start = 1'b0; force_tx_low = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
